// File: rtl/servo_output_limiter.sv
// servo_output_limiter: offset/saturate, clamp with rail flags, slew limit and lock-loss freeze.
// Define SERVO_OUT_SLEW_EN to compile in the stage-3 slew limiter; otherwise stage 3 is a plain register.
module servo_output_limiter #(
  parameter int CNT_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             on_in,
  input  logic [15:0]      signal_in,
  input  logic [15:0]      offset_in,
  input  logic [15:0]      max_in,
  input  logic [15:0]      min_in,
  input  logic [15:0]      slew_in,
  input  logic [CNT_W-1:0] lock_cnt_in,
  input  logic             relock_in,
  output logic [15:0]      signal_out,
  output logic [1:0]       railed_out,
  output logic             unlocked_out,
  output logic [1:0]       state_out
);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_LOCKED = 2'd1, ST_UNLOCKED = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sum_q, sum_d, tgt_q, tgt_d, out_q, out_d, sig_m;
  logic [1:0]       railed_q, railed_d;
  logic [16:0]      sum17;
  logic             off, frz, hi, lo, inv, hit;
`ifdef SERVO_OUT_SLEW_EN
  logic [16:0]      diff, mag;
`else
  logic             unused_slew;
  assign unused_slew = ^slew_in;
`endif
  always_ff @(posedge clk_in) state_q <= rst_in ? ST_OFF : state_d;
  always_comb begin
    hit = (|railed_q) && (lock_cnt_in != '0) &&
          (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, lock_cnt_in});
    state_d = !on_in                 ? ST_OFF :
              state_q == ST_OFF      ? ST_LOCKED :
              state_q == ST_UNLOCKED ? (relock_in ? ST_LOCKED : ST_UNLOCKED) :
              hit                    ? ST_UNLOCKED : ST_LOCKED;
  end
  always_comb begin
    unlocked_out = state_q == ST_UNLOCKED;
    state_out    = state_q;
    signal_out   = out_q;
    railed_out   = railed_q;
  end
  always_comb begin
    off      = state_d == ST_OFF;
    frz      = state_d == ST_UNLOCKED;
    sig_m    = off ? '0 : signal_in;
    sum17    = {sig_m[15], sig_m} + {offset_in[15], offset_in};
    sum_d    = (sum17[16] != sum17[15]) ? (sum17[16] ? 16'h8000 : 16'h7fff) : sum17[15:0];
    inv      = $signed(min_in) > $signed(max_in);
    hi       = $signed(sum_q) > $signed(max_in);
    lo       = $signed(sum_q) < $signed(min_in);
    tgt_d    = (inv || lo) ? min_in : hi ? max_in : sum_q;
    railed_d = off ? 2'b00 : frz ? railed_q : inv ? 2'b11 : {hi, lo};
    // counter only runs while locked; relock or any quiet cycle clears it
    cnt_d    = (off || state_q == ST_OFF || (state_q == ST_UNLOCKED && relock_in) ||
                (state_q != ST_UNLOCKED && !(|railed_q))) ? '0 :
               (state_q == ST_UNLOCKED || &cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SERVO_OUT_SLEW_EN
    diff     = {tgt_q[15], tgt_q} - {out_q[15], out_q};
    mag      = diff[16] ? -diff : diff;
    out_d    = frz ? out_q :
               (slew_in != '0 && mag > {1'b0, slew_in}) ? (diff[16] ? out_q - slew_in : out_q + slew_in) :
               tgt_q;
`else
    out_d    = frz ? out_q : tgt_q;
`endif
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      cnt_q    <= '0;
      sum_q    <= '0;
      tgt_q    <= '0;
      out_q    <= '0;
      railed_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      tgt_q    <= tgt_d;
      out_q    <= out_d;
      railed_q <= railed_d;
    end
endmodule

// File: tb/tb_servo_output_limiter.sv
// tb_servo_output_limiter: directed checks of reset, clamp, saturation, slew, lock-loss and event priority.
module tb_servo_output_limiter;
  logic        clk_in = 1'b0;
  logic        rst_in, on_in, relock_in;
  logic [15:0] signal_in, offset_in, max_in, min_in, slew_in;
  logic [23:0] lock_cnt_in;
  logic [15:0] signal_out;
  logic [1:0]  railed_out, state_out;
  logic        unlocked_out;
  int checks = 0;
  int errors = 0;

  servo_output_limiter #(.CNT_W(24)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .on_in(on_in), .signal_in(signal_in),
    .offset_in(offset_in), .max_in(max_in), .min_in(min_in), .slew_in(slew_in),
    .lock_cnt_in(lock_cnt_in), .relock_in(relock_in), .signal_out(signal_out),
    .railed_out(railed_out), .unlocked_out(unlocked_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1; on_in = 0; relock_in = 0; signal_in = 0; offset_in = 16'd100;
    max_in = 16'h7fff; min_in = 16'h8000; slew_in = 0; lock_cnt_in = 0;
    tick(3);
    checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", $signed(signal_out)); end
    checks++; if (railed_out !== 2'b00) begin errors++; $display("FAIL reset_railed: got %b expected 00", railed_out); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if (unlocked_out !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked_out); end
    rst_in = 0; on_in = 1;
    tick();
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL on_state: got %0d expected 1", state_out); end
    tick();
    checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL on_out_early: got %0d expected 0", $signed(signal_out)); end
    tick();
    checks++; if (signal_out !== 16'd100) begin errors++; $display("FAIL on_out: got %0d expected 100", $signed(signal_out)); end
    checks++; if (railed_out !== 2'b00) begin errors++; $display("FAIL on_railed: got %b expected 00", railed_out); end
  endtask

  task automatic test_clamp;
    offset_in = 0; max_in = 16'd1000; min_in = -16'sd1000; signal_in = 16'd5000;
    tick(2);
    checks++; if (railed_out !== 2'b10) begin errors++; $display("FAIL clamp_hi_flag: got %b expected 10", railed_out); end
    checks++; if (signal_out !== 16'd100) begin errors++; $display("FAIL clamp_hi_lag: got %0d expected 100", $signed(signal_out)); end
    tick();
    checks++; if (signal_out !== 16'd1000) begin errors++; $display("FAIL clamp_hi_out: got %0d expected 1000", $signed(signal_out)); end
    signal_in = -16'sd5000;
    tick(2);
    checks++; if (railed_out !== 2'b01) begin errors++; $display("FAIL clamp_lo_flag: got %b expected 01", railed_out); end
    checks++; if (signal_out !== 16'd1000) begin errors++; $display("FAIL clamp_lo_lag: got %0d expected 1000", $signed(signal_out)); end
    tick();
    checks++; if (signal_out !== -16'sd1000) begin errors++; $display("FAIL clamp_lo_out: got %0d expected -1000", $signed(signal_out)); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL clamp_state: got %0d expected 1", state_out); end
    min_in = 16'd50; max_in = -16'sd50; signal_in = 0;
    tick(3);
    checks++; if (signal_out !== 16'd50) begin errors++; $display("FAIL inverted_out: got %0d expected 50", $signed(signal_out)); end
    checks++; if (railed_out !== 2'b11) begin errors++; $display("FAIL inverted_flags: got %b expected 11", railed_out); end
  endtask

  task automatic test_saturation;
    max_in = 16'h7fff; min_in = 16'h8000; offset_in = 16'd2000; signal_in = 16'd32000;
    tick(3);
    checks++; if (signal_out !== 16'h7fff) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", $signed(signal_out)); end
    checks++; if (railed_out !== 2'b00) begin errors++; $display("FAIL sat_pos_flags: got %b expected 00", railed_out); end
    offset_in = -16'sd2000; signal_in = -16'sd32000;
    tick(3);
    checks++; if (signal_out !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", $signed(signal_out)); end
  endtask

  task automatic test_slew;
    logic [15:0] exp;
    offset_in = 0; signal_in = 0; slew_in = 0;
    tick(3);
    checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL slew_base: got %0d expected 0", $signed(signal_out)); end
    slew_in = 16'd10; signal_in = 16'd100;
    tick(2);
    for (int k = 1; k <= 11; k++) begin
      tick();
`ifdef SERVO_OUT_SLEW_EN
      exp = (k >= 10) ? 16'd100 : 16'(10 * k);
`else
      exp = 16'd100;
`endif
      checks++; if (signal_out !== exp) begin errors++; $display("FAIL slew_step%0d: got %0d expected %0d", k, $signed(signal_out), exp); end
    end
    slew_in = 0;
  endtask

  task automatic test_unlock;
    max_in = 16'd1000; min_in = -16'sd1000; offset_in = 0; signal_in = 0; lock_cnt_in = 24'd5;
    tick(4);
    signal_in = 16'd5000;
    tick(6);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL unlock_early: got %0d expected 1", state_out); end
    tick();
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL unlock_state: got %0d expected 2", state_out); end
    checks++; if (unlocked_out !== 1'b1) begin errors++; $display("FAIL unlock_flag: got %b expected 1", unlocked_out); end
    signal_in = -16'sd5000;
    tick(5);
    checks++; if (signal_out !== 16'd1000) begin errors++; $display("FAIL freeze_out: got %0d expected 1000", $signed(signal_out)); end
    checks++; if (railed_out !== 2'b10) begin errors++; $display("FAIL freeze_railed: got %b expected 10", railed_out); end
    relock_in = 1;
    tick();
    relock_in = 0;
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL relock_state: got %0d expected 1", state_out); end
    checks++; if (signal_out !== -16'sd1000) begin errors++; $display("FAIL relock_out: got %0d expected -1000", $signed(signal_out)); end
    tick(4);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL relock_count4: got %0d expected 1", state_out); end
    tick();
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL relock_count5: got %0d expected 2", state_out); end
    on_in = 0; signal_in = 0;
    tick(4);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL off_state: got %0d expected 0", state_out); end
    checks++; if (railed_out !== 2'b00) begin errors++; $display("FAIL off_railed: got %b expected 00", railed_out); end
    checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL off_out: got %0d expected 0", $signed(signal_out)); end
    on_in = 1;
    tick(4);
    signal_in = 16'd5000; tick(4);
    signal_in = 0;        tick(1);
    signal_in = 16'd5000; tick(4);
    signal_in = 0;        tick(4);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL four_railed: got %0d expected 1", state_out); end
  endtask

  task automatic test_simultaneous;
    int n;
    on_in = 1; lock_cnt_in = 24'd5; signal_in = 16'd5000;
    n = 0;
    while (state_out !== 2'd2 && n < 20) begin tick(); n++; end
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL sim_reach_unlock: got %0d expected 2", state_out); end
    relock_in = 1; on_in = 0;
    tick();
    relock_in = 0;
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL sim_off_wins: got %0d expected 0", state_out); end
    checks++; if (unlocked_out !== 1'b0) begin errors++; $display("FAIL sim_off_unlocked: got %b expected 0", unlocked_out); end
    on_in = 1; lock_cnt_in = 0;
    tick(20);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL monitor_off_state: got %0d expected 1", state_out); end
    checks++; if (railed_out !== 2'b10) begin errors++; $display("FAIL monitor_off_railed: got %b expected 10", railed_out); end
    checks++; if (signal_out !== 16'd1000) begin errors++; $display("FAIL monitor_off_out: got %0d expected 1000", $signed(signal_out)); end
    slew_in = 16'd10; rst_in = 1;
    tick();
    checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL midreset_out: got %0d expected 0", $signed(signal_out)); end
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", state_out); end
    checks++; if (railed_out !== 2'b00) begin errors++; $display("FAIL midreset_railed: got %b expected 00", railed_out); end
    rst_in = 0; slew_in = 0;
  endtask

  initial begin
    test_reset;
    test_clamp;
    test_saturation;
    test_slew;
    test_unlock;
    test_simultaneous;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
